pwm_multi_channel: RTL and testbench



---
 rtl/pwm_pkg.sv | 32 +++
 rtl/pwm_prescaler.sv | 47 ++++
 rtl/pwm_multi_channel.sv | 183 ++++++++++++++++++
 tb/tb_pwm_multi_channel.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// +----------------------------------------------------------------------+
// | pwm_pkg : register map offsets, reset constants and mode enum        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pwm_pkg;

  // Duty registers start at address 0; the rest are offsets past NUM_CH.
  localparam int ADDR_DUTY_BASE = 0;
  localparam int ADDR_PERIOD    = 0;
  localparam int ADDR_ENABLE    = 1;
  localparam int ADDR_PRESC     = 2;
  localparam int ADDR_MODE      = 3;

  localparam int RST_DUTY        = 0;
  localparam int RST_MASK        = 0;
  localparam int RST_PRESC       = 0;
  localparam bit RST_PERIOD_ONES = 1'b1;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  function automatic int reg_addr(input int base, input int offset);
    return base + offset;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_prescaler.sv
// +----------------------------------------------------------------------+
// | pwm_prescaler : programmable divider producing the timebase tick     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena_i,
  input  logic               wr_i,
  input  logic [PRESC_W-1:0] wr_data_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic [PRESC_W-1:0] presc_cnt_q;
  logic [PRESC_W-1:0] presc_cnt_d;
  logic [PRESC_W-1:0] w_cnt_nxt;

  assign tick_o = ena_i && (presc_cnt_q == presc_q);

  always_comb begin
    presc_d     = wr_i ? wr_data_i : presc_q;
    w_cnt_nxt   = (!ena_i || tick_o) ? '0 : presc_cnt_q + PRESC_W'(1);
    // A shrinking divider must not leave the count stranded above the new limit.
    presc_cnt_d = (wr_i && (w_cnt_nxt > wr_data_i)) ? '0 : w_cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q     <= PRESC_W'(RST_PRESC);
      presc_cnt_q <= '0;
    end else begin
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_multi_channel.sv
// +----------------------------------------------------------------------+
// | pwm_multi_channel : N-channel double-buffered PWM, shared timebase   |
// | Optional centre-aligned mode: define PWM_CENTER_ALIGN_EN   Rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4,
  parameter int ADDR_W  = $clog2(NUM_CH + 4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              period_tick
);

  localparam logic [ADDR_W-1:0] c_addr_period = ADDR_W'(reg_addr(NUM_CH, ADDR_PERIOD));
  localparam logic [ADDR_W-1:0] c_addr_enable = ADDR_W'(reg_addr(NUM_CH, ADDR_ENABLE));
  localparam logic [ADDR_W-1:0] c_addr_presc  = ADDR_W'(reg_addr(NUM_CH, ADDR_PRESC));

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_stg_q, period_stg_d;
  logic [CNT_W-1:0]  period_act_q, period_act_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] pwm_q, w_pwm_d;
  logic              period_tick_q;
  logic              w_tick;
  logic              w_wrap;
  logic              w_copy;

`ifdef PWM_CENTER_ALIGN_EN
  localparam logic [ADDR_W-1:0] c_addr_mode = ADDR_W'(reg_addr(NUM_CH, ADDR_MODE));
  pwm_mode_e mode_stg_q, mode_stg_d;
  pwm_mode_e mode_act_q, mode_act_d;
  logic      dir_q, dir_d;
`endif

  pwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena_i     (ena),
    .wr_i      (wr_en && (wr_addr == c_addr_presc)),
    .wr_data_i (wr_data[PRESC_W-1:0]),
    .tick_o    (w_tick)
  );

  // Shadow registers reload at each period boundary, and continuously while idle.
  assign w_copy = w_wrap || !ena;

  always_comb begin
    period_stg_d = period_stg_q;
    en_d         = en_q;
    if (wr_en && (wr_addr == c_addr_period)) period_stg_d = wr_data;
    if (wr_en && (wr_addr == c_addr_enable)) en_d = wr_data[NUM_CH-1:0];
  end

  assign period_act_d = w_copy ? period_stg_q : period_act_q;

`ifdef PWM_CENTER_ALIGN_EN
  always_comb begin
    mode_stg_d = mode_stg_q;
    if (wr_en && (wr_addr == c_addr_mode)) mode_stg_d = pwm_mode_e'(wr_data[0]);
  end

  assign mode_act_d = w_copy ? mode_stg_q : mode_act_q;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    w_wrap = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d  = dir_q;
`endif
    if (!ena) begin
      cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d = 1'b0;
`endif
    end else if (w_tick) begin
`ifdef PWM_CENTER_ALIGN_EN
      if (mode_act_q == MODE_CENTER) begin
        // dir_q=0 counts up; the wrap happens on the step that lands on 0.
        if (!dir_q) begin
          if (cnt_q != period_act_q) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (period_act_q <= CNT_W'(1)) begin
            cnt_d  = '0;
            w_wrap = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            dir_d = 1'b1;
          end
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d  = '0;
          dir_d  = 1'b0;
          w_wrap = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (cnt_q == period_act_q) begin
        cnt_d  = '0;
        w_wrap = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`else
      if (cnt_q == period_act_q) begin
        cnt_d  = '0;
        w_wrap = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`endif
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [ADDR_W-1:0] c_addr_duty = ADDR_W'(reg_addr(ADDR_DUTY_BASE, i));

    logic [CNT_W-1:0] duty_stg_q, duty_stg_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;

    assign duty_stg_d = (wr_en && (wr_addr == c_addr_duty)) ? wr_data : duty_stg_q;
    assign duty_act_d = w_copy ? duty_stg_q : duty_act_q;
    assign w_pwm_d[i] = ena && en_q[i] && (cnt_q < duty_act_q);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        duty_stg_q <= CNT_W'(RST_DUTY);
        duty_act_q <= CNT_W'(RST_DUTY);
      end else begin
        duty_stg_q <= duty_stg_d;
        duty_act_q <= duty_act_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      period_stg_q  <= {CNT_W{RST_PERIOD_ONES}};
      period_act_q  <= {CNT_W{RST_PERIOD_ONES}};
      en_q          <= NUM_CH'(RST_MASK);
      pwm_q         <= '0;
      period_tick_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      mode_stg_q    <= MODE_EDGE;
      mode_act_q    <= MODE_EDGE;
      dir_q         <= 1'b0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      period_stg_q  <= period_stg_d;
      period_act_q  <= period_act_d;
      en_q          <= en_d;
      pwm_q         <= w_pwm_d;
      period_tick_q <= w_wrap;
`ifdef PWM_CENTER_ALIGN_EN
      mode_stg_q    <= mode_stg_d;
      mode_act_q    <= mode_act_d;
      dir_q         <= dir_d;
`endif
    end
  end

  assign pwm_out     = pwm_q;
  assign cnt_out     = cnt_q;
  assign period_tick = period_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
// +----------------------------------------------------------------------+
// | tb_pwm_multi_channel : directed bench with period-position model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pwm_multi_channel;

  localparam int NUM_CH  = 8;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 4;
  localparam int ADDR_W  = $clog2(NUM_CH + 4);
`ifdef PWM_CENTER_ALIGN_EN
  localparam bit HAS_CENTER = 1'b1;
`else
  localparam bit HAS_CENTER = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic [NUM_CH-1:0] pwm_out;
  logic [CNT_W-1:0]  cnt_out;
  logic              period_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_multi_channel #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .cnt_out     (cnt_out),
    .period_tick (period_tick)
  );

  // Model: the timebase is a position within a period of known length.
  int m_presc, m_pc, m_pos, m_per, m_per_stg, m_mode, m_mode_stg, m_en;
  int m_duty [NUM_CH];
  int m_duty_stg [NUM_CH];
  logic [NUM_CH-1:0] m_pwm;
  logic m_tick;
  bit   m_valid = 1'b0;
  bit   t_tick, t_wrap;
  int   t_cur, t_pcn, t_a, t_d;

  function automatic int len_of(input int per, input int mode);
    if (mode != 0 && per > 0) return 2 * per;
    return per + 1;
  endfunction

  function automatic int cnt_of(input int pos, input int per, input int mode);
    if (mode != 0 && pos > per) return 2 * per - pos;
    return pos;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_presc = 0; m_pc = 0; m_pos = 0; m_per = 255; m_per_stg = 255;
      m_mode = 0; m_mode_stg = 0; m_en = 0; m_pwm = '0; m_tick = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_duty[i] = 0;
        m_duty_stg[i] = 0;
      end
      m_valid = 1'b1;
    end else begin
      t_cur  = cnt_of(m_pos, m_per, m_mode);
      t_tick = ena && (m_pc == m_presc);
      t_wrap = t_tick && (m_pos == len_of(m_per, m_mode) - 1);
      for (int i = 0; i < NUM_CH; i++)
        m_pwm[i] = ena && (((m_en >> i) & 1) == 1) && (t_cur < m_duty[i]);
      m_tick = t_wrap;
      if (!ena) m_pos = 0;
      else if (t_tick) m_pos = t_wrap ? 0 : m_pos + 1;
      if (t_wrap || !ena) begin
        m_per  = m_per_stg;
        m_mode = m_mode_stg;
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_duty_stg[i];
      end
      t_pcn = (!ena || t_tick) ? 0 : m_pc + 1;
      if (wr_en) begin
        t_a = int'(wr_addr);
        t_d = int'(wr_data);
        if (t_a < NUM_CH) m_duty_stg[t_a] = t_d;
        else if (t_a == NUM_CH) m_per_stg = t_d;
        else if (t_a == NUM_CH + 1) m_en = t_d & ((1 << NUM_CH) - 1);
        else if (t_a == NUM_CH + 2) begin
          m_presc = t_d % (1 << PRESC_W);
          if (t_pcn > m_presc) t_pcn = 0;
        end else if (t_a == NUM_CH + 3 && HAS_CENTER) m_mode_stg = t_d & 1;
      end
      m_pc = t_pcn;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      checks++;
      if (pwm_out !== m_pwm) begin
        errors++;
        $display("FAIL model_pwm t=%0t got %h expected %h", $time, pwm_out, m_pwm);
      end
      checks++;
      if (int'(cnt_out) != cnt_of(m_pos, m_per, m_mode)) begin
        errors++;
        $display("FAIL model_cnt t=%0t got %0d expected %0d", $time, cnt_out,
                 cnt_of(m_pos, m_per, m_mode));
      end
      checks++;
      if (period_tick !== m_tick) begin
        errors++;
        $display("FAIL model_tick t=%0t got %b expected %b", $time, period_tick, m_tick);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = CNT_W'(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  int maxc;
  int highs [NUM_CH];

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (int'(cnt_out) > maxc) maxc = int'(cnt_out);
    end while (period_tick !== 1'b1 && n < budget);
    if (period_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got none expected tick within %0d cycles", budget);
      n = -1;
    end
  endtask

  task automatic measure(input int ncyc);
    for (int i = 0; i < NUM_CH; i++) highs[i] = 0;
    for (int k = 0; k < ncyc; k++) begin
      for (int i = 0; i < NUM_CH; i++) highs[i] += int'(pwm_out[i]);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h, others;
    bit done;
    int exp_seq [8];
    exp_seq = '{0, 1, 2, 3, 4, 3, 2, 1};

    repeat (3) @(negedge clk);
    check("reset_cnt", int'(cnt_out), 0);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_tick", int'(period_tick), 0);
    rst_n = 1'b1;
    @(negedge clk);
    ena = 1'b1;

    // Reset period is all-ones.
    wait_tick(300, n);
    maxc = 0;
    wait_tick(300, n);
    check("default_period_interval", n, 256);
    check("default_period_max_cnt", maxc, 255);

    // period 9, duty0 5, channel 0 only
    wr(NUM_CH, 9); wr(0, 5); wr(NUM_CH + 1, 1);
    wait_tick(300, n);
    wait_tick(20, n);
    check("p9_interval", n, 10);
    measure(10);
    others = 0;
    for (int i = 1; i < NUM_CH; i++) others += highs[i];
    check("p9_duty0_highs", highs[0], 5);
    check("p9_other_highs", others, 0);

    // duty 0 and duty > period, plus writes that must be ignored
    wr(1, 0); wr(2, 20); wr(NUM_CH + 1, 6); wr(15, 8'hAA);
`ifndef PWM_CENTER_ALIGN_EN
    wr(NUM_CH + 3, 1);
`endif
    wait_tick(20, n);
    wait_tick(20, n);
    measure(10);
    check("duty0_const_low", highs[1], 0);
    check("duty_gt_period_const_high", highs[2], 10);
    check("masked_ch0_low", highs[0], 0);

    // duty0 5 -> 2 written mid-period
    wr(NUM_CH + 1, 1);
    wait_tick(20, n);
    wait_tick(20, n);
    h = 0;
    done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      h += int'(pwm_out[0]);
      if (!done && cnt_out == CNT_W'(3)) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = CNT_W'(2); done = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("duty_change_write_seen", int'(done), 1);
    check("duty_change_cur_period", h, 5);
    measure(10);
    check("duty_change_next_period", highs[0], 2);

    // prescaler 3
    wr(NUM_CH + 2, 3);
    wait_tick(100, n);
    wait_tick(100, n);
    check("presc3_interval", n, 40);
    repeat (3) @(negedge clk);
    check("presc3_hold", int'(cnt_out), 0);
    @(negedge clk);
    check("presc3_step", int'(cnt_out), 1);
    ena = 1'b0;
    @(negedge clk);
    check("ena_off_cnt", int'(cnt_out), 0);
    check("ena_off_pwm", int'(pwm_out), 0);
    check("ena_off_tick", int'(period_tick), 0);
    wr(NUM_CH + 2, 0);
    ena = 1'b1;

    // reset mid-period
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cnt", int'(cnt_out), 0);
    check("midrst_pwm", int'(pwm_out), 0);
    check("midrst_tick", int'(period_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(300, n);
    wait_tick(300, n);
    check("post_reset_period_interval", n, 256);

`ifdef PWM_CENTER_ALIGN_EN
    wr(NUM_CH + 3, 1); wr(NUM_CH, 4); wr(0, 2); wr(NUM_CH + 1, 1);
    wait_tick(300, n);
    wait_tick(20, n);
    check("center_interval", n, 8);
    h = 0;
    for (int k = 0; k < 8; k++) begin
      check("center_cnt_seq", int'(cnt_out), exp_seq[k]);
      h += int'(pwm_out[0]);
      @(negedge clk);
    end
    check("center_duty0_highs", h, 3);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
